dff_error_deserializer: RTL and testbench

// - Receive end of the DFF error-count serial link: samples the 1-bit stream on data_clk and rebuilds
//   NUM_WORDS x WORD_W error-count words, transmitted LSB-first, word 0 first.
// - Sits on the capture side (tester FPGA / loopback bench). Stores one complete frame in a register

---
 rtl/dff_error_deserializer_if.sv | 26 ++
 rtl/dff_error_deserializer.sv | 131 +++++++++++++
 tb/tb_dff_error_deserializer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dff_error_deserializer_if.sv
// Bundles the serial-link receive controls, word strobe outputs and the bank read port.
interface dff_error_deserializer_if #(
  parameter int WORD_W = 32
);
  logic              DATA_IN;
  logic              rx_start;
  logic              continuous;
  logic              busy;
  logic              word_valid;
  logic [3:0]        word_index;
  logic [WORD_W-1:0] word_data;
  logic              frame_done;
  logic [15:0]       frame_count;
  logic [3:0]        rd_addr;
  logic [WORD_W-1:0] rd_data;

  modport slave (
    input  DATA_IN, rx_start, continuous, rd_addr,
    output busy, word_valid, word_index, word_data, frame_done, frame_count, rd_data
  );

  modport master (
    output DATA_IN, rx_start, continuous, rd_addr,
    input  busy, word_valid, word_index, word_data, frame_done, frame_count, rd_data
  );
endinterface

// File: rtl/dff_error_deserializer.sv
// Rebuilds NUM_WORDS x WORD_W error-count words from the LSB-first serial link into a register bank.
module dff_error_deserializer #(
  parameter int NUM_WORDS  = 14,
  parameter int WORD_W     = 32,
  parameter int START_SKIP = 0
) (
  input logic                     data_clk,
  input logic                     reset,
  dff_error_deserializer_if.slave bus
);

  localparam int              BW        = $clog2(WORD_W);
  localparam logic [BW-1:0]   LAST_BIT  = BW'(WORD_W - 1);
  localparam logic [3:0]      LAST_WORD = 4'(NUM_WORDS - 1);
  localparam logic [3:0]      LAST_SKIP = 4'(START_SKIP - 1);
  localparam logic [4:0]      NW        = 5'(NUM_WORDS);

  typedef enum logic [1:0] {IDLE, SKIP, SHIFT} state_t;
  localparam state_t START_STATE = (START_SKIP > 0) ? SKIP : SHIFT;

  state_t            r_state;
  logic [WORD_W-1:0] r_sr;
  logic [BW-1:0]     r_bit_cnt;
  logic [3:0]        r_word_cnt;
  logic [3:0]        r_skip_cnt;
  logic              r_word_valid;
  logic              r_frame_done;
  logic [3:0]        r_word_index;
  logic [WORD_W-1:0] r_word_data;
  logic [15:0]       r_frame_count;
  logic [WORD_W-1:0] r_rd_data;
  logic [WORD_W-1:0] r_bank [NUM_WORDS];

  logic [WORD_W-1:0] w_shift;
  logic              w_last_bit;

  assign w_shift    = {bus.DATA_IN, r_sr[WORD_W-1:1]};
  assign w_last_bit = (r_bit_cnt == LAST_BIT);

  always_ff @(posedge data_clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_sr          <= '0;
      r_bit_cnt     <= '0;
      r_word_cnt    <= '0;
      r_skip_cnt    <= '0;
      r_word_valid  <= 1'b0;
      r_frame_done  <= 1'b0;
      r_word_index  <= '0;
      r_word_data   <= '0;
      r_frame_count <= '0;
      r_rd_data     <= '0;
      for (int unsigned i = 0; i < NUM_WORDS; i++) r_bank[i] <= '0;
    end else begin
      r_word_valid <= 1'b0;
      r_frame_done <= 1'b0;
      r_rd_data    <= ({1'b0, bus.rd_addr} < NW) ? r_bank[bus.rd_addr] : '0;

      case (r_state)
        IDLE: begin
          if (bus.rx_start) begin
            r_state    <= START_STATE;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_skip_cnt <= '0;
          end
        end

        SKIP: begin
          if (bus.rx_start) begin
            r_state    <= START_STATE;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_skip_cnt <= '0;
          end else if (r_skip_cnt == LAST_SKIP) begin
            r_state    <= SHIFT;
            r_skip_cnt <= '0;
          end else begin
            r_skip_cnt <= r_skip_cnt + 4'd1;
          end
        end

        SHIFT: begin
          // The final bit of a frame always completes, even if a restart arrives on the same edge.
          if (w_last_bit && (r_word_cnt == LAST_WORD)) begin
            r_sr          <= w_shift;
            r_word_data   <= w_shift;
            r_bank[r_word_cnt] <= w_shift;
            r_word_index  <= r_word_cnt;
            r_word_valid  <= 1'b1;
            r_frame_done  <= 1'b1;
            r_frame_count <= r_frame_count + 16'd1;
            r_bit_cnt     <= '0;
            r_word_cnt    <= '0;
            r_skip_cnt    <= '0;
            if (bus.rx_start)        r_state <= START_STATE;
            else if (!bus.continuous) r_state <= IDLE;
          end else if (bus.rx_start) begin
            r_state    <= START_STATE;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
            r_skip_cnt <= '0;
          end else begin
            r_sr <= w_shift;
            if (w_last_bit) begin
              r_word_data        <= w_shift;
              r_bank[r_word_cnt] <= w_shift;
              r_word_index       <= r_word_cnt;
              r_word_valid       <= 1'b1;
              r_bit_cnt          <= '0;
              r_word_cnt         <= r_word_cnt + 4'd1;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = (r_state != IDLE);
  assign bus.word_valid  = r_word_valid;
  assign bus.word_index  = r_word_index;
  assign bus.word_data   = r_word_data;
  assign bus.frame_done  = r_frame_done;
  assign bus.frame_count = r_frame_count;
  assign bus.rd_data     = r_rd_data;

endmodule

// File: tb/tb_dff_error_deserializer.sv
// Scoreboard bench: stimulus pushes expected words, negedge monitors pop and compare on word_valid.
module tb_dff_error_deserializer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dff_error_deserializer_if #(.WORD_W(32)) bus0 ();
  dff_error_deserializer_if #(.WORD_W(32)) bus1 ();

  dff_error_deserializer #(.NUM_WORDS(14), .WORD_W(32), .START_SKIP(0)) u_dut (
    .data_clk (clk),
    .reset    (reset),
    .bus      (bus0)
  );

  dff_error_deserializer #(.NUM_WORDS(14), .WORD_W(32), .START_SKIP(3)) u_dut_skip (
    .data_clk (clk),
    .reset    (reset),
    .bus      (bus1)
  );

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] data;
    logic        fd;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int fd_n0   = 0;
  int fd_n1   = 0;
  int busy_cnt = 0;
  int fd_time[8];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor for the START_SKIP=0 instance
  always @(negedge clk) begin
    exp_t e;
    if (bus0.word_valid) begin
      if (q0.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dut0 unexpected word: got idx %0d data 0x%08h, expected no word",
                 bus0.word_index, bus0.word_data);
      end else begin
        e = q0.pop_front();
        chk("dut0 word_index", {28'd0, bus0.word_index}, {28'd0, e.idx});
        chk("dut0 word_data", bus0.word_data, e.data);
        chk("dut0 frame_done", {31'd0, bus0.frame_done}, {31'd0, e.fd});
      end
    end else if (bus0.frame_done) begin
      n_tests++; n_fail++;
      $display("FAIL dut0 frame_done without word_valid: got 1 expected 0");
    end
    if (bus0.frame_done) begin
      if (fd_n0 < 8) fd_time[fd_n0] = cyc;
      fd_n0++;
    end
    if (bus0.busy) busy_cnt++;
  end

  // Monitor for the START_SKIP=3 instance
  always @(negedge clk) begin
    exp_t e;
    if (bus1.word_valid) begin
      if (q1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dut1 unexpected word: got idx %0d data 0x%08h, expected no word",
                 bus1.word_index, bus1.word_data);
      end else begin
        e = q1.pop_front();
        chk("dut1 word_index", {28'd0, bus1.word_index}, {28'd0, e.idx});
        chk("dut1 word_data", bus1.word_data, e.data);
        chk("dut1 frame_done", {31'd0, bus1.frame_done}, {31'd0, e.fd});
      end
    end else if (bus1.frame_done) begin
      n_tests++; n_fail++;
      $display("FAIL dut1 frame_done without word_valid: got 1 expected 0");
    end
    if (bus1.frame_done) fd_n1++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // Inputs change 2 time units after each rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_bit(input logic b);
    bus0.DATA_IN = b;
    tick();
  endtask

  task automatic start0();
    bus0.rx_start = 1'b1;
    tick();
    bus0.rx_start = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] idx, input logic [31:0] d, input bit expect_it);
    if (expect_it) q0.push_back('{idx, d, (idx == 4'd13)});
    for (int i = 0; i < 32; i++) send_bit(d[i]);
  endtask

  task automatic rd0(input logic [3:0] addr, input logic [31:0] exp, input string name);
    bus0.rd_addr = addr;
    tick();
    chk(name, bus0.rd_data, exp);
  endtask

  task automatic drain0();
    tick(); tick();
    chk("dut0 scoreboard empty", q0.size(), 0);
  endtask

  initial begin
    reset = 1'b0;
    bus0.DATA_IN = 1'b0; bus0.rx_start = 1'b0; bus0.continuous = 1'b0; bus0.rd_addr = '0;
    bus1.DATA_IN = 1'b0; bus1.rx_start = 1'b0; bus1.continuous = 1'b0; bus1.rd_addr = '0;
    tick(); tick();
    chk("reset busy", {31'd0, bus0.busy}, 0);
    chk("reset word_valid", {31'd0, bus0.word_valid}, 0);
    chk("reset frame_count", {16'd0, bus0.frame_count}, 0);
    chk("reset word_data", bus0.word_data, 0);
    chk("reset rd_data", bus0.rd_data, 0);
    reset = 1'b1;
    tick();

    // Frame of word k = k
    fd_n0 = 0;
    start0();
    for (int k = 0; k < 14; k++) send_word(4'(k), 32'(k), 1'b1);
    drain0();
    chk("t1 frame_count", {16'd0, bus0.frame_count}, 1);
    chk("t1 frame_done pulses", fd_n0, 1);
    rd0(4'd5, 32'h5, "t1 rd[5]");

    // Pattern frame and out-of-range reads
    start0();
    send_word(4'd0, 32'h8000_0001, 1'b1);
    for (int k = 1; k < 13; k++) send_word(4'(k), 32'hA5A5_A5A5, 1'b1);
    send_word(4'd13, 32'hDEAD_BEEF, 1'b1);
    drain0();
    chk("t2 word_data held", bus0.word_data, 32'hDEAD_BEEF);
    chk("t2 frame_count", {16'd0, bus0.frame_count}, 2);
    rd0(4'd0, 32'h8000_0001, "t2 rd[0]");
    rd0(4'd7, 32'hA5A5_A5A5, "t2 rd[7]");
    rd0(4'd13, 32'hDEAD_BEEF, "t2 rd[13]");
    rd0(4'd14, 32'h0, "t2 rd[14]");
    rd0(4'd15, 32'h0, "t2 rd[15]");

    // Three back-to-back continuous frames; continuous dropped during the third
    fd_n0 = 0;
    busy_cnt = 0;
    bus0.continuous = 1'b1;
    start0();
    for (int f = 0; f < 3; f++) begin
      if (f == 2) bus0.continuous = 1'b0;
      for (int k = 0; k < 14; k++) send_word(4'(k), 32'((f << 8) + k), 1'b1);
    end
    drain0();
    chk("cont frame_done pulses", fd_n0, 3);
    chk("cont spacing 0-1", fd_time[1] - fd_time[0], 448);
    chk("cont spacing 1-2", fd_time[2] - fd_time[1], 448);
    chk("cont busy cycles", busy_cnt, 1344);
    chk("cont frame_count", {16'd0, bus0.frame_count}, 5);
    chk("cont busy after end", {31'd0, bus0.busy}, 0);

    // Reset asserted at bit 200
    start0();
    for (int k = 0; k < 6; k++) send_word(4'(k), 32'h60 + 32'(k), 1'b1);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    bus0.rd_addr = 4'd3;
    reset = 1'b0;
    #1;
    chk("rst busy", {31'd0, bus0.busy}, 0);
    chk("rst word_valid", {31'd0, bus0.word_valid}, 0);
    chk("rst frame_done", {31'd0, bus0.frame_done}, 0);
    chk("rst frame_count", {16'd0, bus0.frame_count}, 0);
    chk("rst word_data", bus0.word_data, 0);
    chk("rst word_index", {28'd0, bus0.word_index}, 0);
    chk("rst rd_data", bus0.rd_data, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("rst scoreboard empty", q0.size(), 0);
    rd0(4'd3, 32'h0, "rst bank[3]");

    // Abort after 100 bits, then a full frame of 0x11111111
    fd_n0 = 0;
    start0();
    for (int k = 0; k < 3; k++) send_word(4'(k), 32'hAAAA_0000 + 32'(k), 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    start0();
    for (int k = 0; k < 14; k++) send_word(4'(k), 32'h1111_1111, 1'b1);
    drain0();
    chk("abort frame_done pulses", fd_n0, 1);
    chk("abort frame_count", {16'd0, bus0.frame_count}, 1);
    for (int k = 0; k < 14; k++) rd0(4'(k), 32'h1111_1111, "abort bank");

    // START_SKIP=3 instance: three garbage 1-bits precede the frame
    bus1.rx_start = 1'b1;
    tick();
    bus1.rx_start = 1'b0;
    bus1.DATA_IN = 1'b1;
    tick(); tick(); tick();
    for (int k = 0; k < 14; k++) begin
      logic [31:0] d;
      d = (k == 0) ? 32'h1234_5678 : 32'(k);
      q1.push_back('{4'(k), d, (k == 13)});
      for (int i = 0; i < 32; i++) begin
        bus1.DATA_IN = d[i];
        tick();
      end
    end
    tick(); tick();
    chk("skip scoreboard empty", q1.size(), 0);
    chk("skip frame_done pulses", fd_n1, 1);
    chk("skip frame_count", {16'd0, bus1.frame_count}, 1);
    bus1.rd_addr = 4'd0;
    tick();
    chk("skip rd[0]", bus1.rd_data, 32'h1234_5678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
